// File: rtl/banco_reg.sv
// Integer register file for the RV64 datapath: 32 x 64-bit registers, two
// combinational read ports, one synchronous write port, x0 hardwired to zero.
module banco_reg #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] regreader1,
  input  logic [ADDR_WIDTH-1:0] regreader2,
  input  logic [ADDR_WIDTH-1:0] regwriteaddress,
  input  logic [DATA_WIDTH-1:0] datain,
  output logic [DATA_WIDTH-1:0] dataout1,
  output logic [DATA_WIDTH-1:0] dataout2
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Register 0 is never written, so it holds its reset value of zero forever.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write && (regwriteaddress != '0)) begin
      regs[regwriteaddress] <= datain;
    end
  end

  // Reads deliberately have no write bypass: a same-cycle write shows up only after the edge.
  always_comb begin
    dataout1 = regs[regreader1];
    dataout2 = regs[regreader2];
  end

endmodule

// File: tb/tb_banco_reg.sv
// Directed self-checking bench for banco_reg: reset, fill, x0 protection,
// write enable, read-during-write and asynchronous reset mid-run.
module tb_banco_reg;

  localparam int DW = 64;
  localparam int AW = 5;

  logic          clock;
  logic          reset;
  logic          write;
  logic [AW-1:0] regreader1;
  logic [AW-1:0] regreader2;
  logic [AW-1:0] regwriteaddress;
  logic [DW-1:0] datain;
  logic [DW-1:0] dataout1;
  logic [DW-1:0] dataout2;

  int compared   = 0;
  int mismatched = 0;

  banco_reg #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(32)) dut (
    .clock(clock),
    .reset(reset),
    .write(write),
    .regreader1(regreader1),
    .regreader2(regreader2),
    .regwriteaddress(regwriteaddress),
    .datain(datain),
    .dataout1(dataout1),
    .dataout2(dataout2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic applyStimulus(input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    write           = wr;
    regwriteaddress = wa;
    datain          = wd;
  endtask

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    reset      = 1'b1;
    regreader1 = '0;
    regreader2 = '0;
    applyStimulus(1'b0, '0, '0);

    // Reset held for two cycles, then every address must read zero.
    repeat (2) @(posedge clock);
    #1 checkOutput("reset_held_port1", dataout1, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      regreader1 = AW'(i);
      #1 checkOutput($sformatf("reset_sweep_r%0d", i), dataout1, 64'd0);
    end

    // Fill register k with value k, one write per cycle.
    for (int k = 1; k < 32; k++) begin
      @(negedge clock);
      applyStimulus(1'b1, AW'(k), DW'(k));
    end
    @(negedge clock);
    applyStimulus(1'b0, '0, '0);
    for (int i = 0; i < 32; i++) begin
      regreader1 = AW'(i);
      regreader2 = AW'(31 - i);
      #1;
      checkOutput($sformatf("fill_port1_r%0d", i), dataout1, DW'(i));
      checkOutput($sformatf("fill_port2_r%0d", 31 - i), dataout2, DW'(31 - i));
    end

    // Writes to x0 are discarded.
    @(negedge clock);
    regreader1 = '0;
    applyStimulus(1'b1, '0, 64'hDEAD_BEEF_0000_0001);
    @(negedge clock);
    applyStimulus(1'b0, '0, '0);
    #1 checkOutput("x0_protect", dataout1, 64'd0);

    // write=0 leaves reg5 untouched.
    applyStimulus(1'b0, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF);
    regreader1 = 5'd5;
    @(negedge clock);
    #1 checkOutput("write_disabled_r5", dataout1, 64'd5);

    // Read-during-write to reg7: old value before the edge, new value after.
    regreader1 = 5'd7;
    regreader2 = 5'd7;
    applyStimulus(1'b1, 5'd7, 64'h1234);
    #1;
    checkOutput("rdw_before_port1", dataout1, 64'd7);
    checkOutput("rdw_before_port2", dataout2, 64'd7);
    @(posedge clock);
    #1;
    checkOutput("rdw_after_port1", dataout1, 64'h1234);
    checkOutput("rdw_after_port2", dataout2, 64'h1234);
    @(negedge clock);
    applyStimulus(1'b0, '0, '0);

    // Asynchronous reset between edges clears reads immediately.
    regreader1 = 5'd3;
    regreader2 = 5'd31;
    #1;
    checkOutput("pre_reset_port1", dataout1, 64'd3);
    checkOutput("pre_reset_port2", dataout2, 64'd31);
    reset = 1'b1;
    #1;
    checkOutput("async_reset_port1", dataout1, 64'd0);
    checkOutput("async_reset_port2", dataout2, 64'd0);

    // A write presented while reset is high must be lost.
    applyStimulus(1'b1, 5'd9, 64'hAA);
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(1'b0, '0, '0);
    for (int i = 0; i < 32; i++) begin
      regreader1 = AW'(i);
      regreader2 = AW'(31 - i);
      #1;
      checkOutput($sformatf("post_reset_port1_r%0d", i), dataout1, 64'd0);
      checkOutput($sformatf("post_reset_port2_r%0d", 31 - i), dataout2, 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
